// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle RV32I load/store unit.
// Computes the effective address and runs a single req/ack transaction on the
// data-memory bus. Byte enables and store data are lane-shifted; load data is
// sign- or zero-extended. A bus timeout of BUS_TIMEOUT cycles aborts the access
// (0 disables the timeout).
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned H/W accesses
// without touching the bus.
module lsu_ctrl #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_val_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs2_val_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] load_result_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, ADDR, REQ, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] ea_reg, ea_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic        we_reg, we_next;
  logic [31:0] rs2_reg, rs2_next;
  logic [3:0]  be_reg, be_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] load_result_reg, load_result_next;
  logic        bus_err_reg, bus_err_next;

  // Access-size decode and lane helpers derived from the captured operands.
  logic [1:0]  lane;
  logic        size_b, size_h;
  logic        misalign;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] byte_sh, half_sh;
  logic [31:0] load_ext;

  assign lane   = ea_reg[1:0];
  assign size_b = (funct3_reg[1:0] == 2'b00);
  assign size_h = (funct3_reg[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
  assign misalign = (size_h && ea_reg[0]) ||
                    (!size_b && !size_h && (ea_reg[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Byte enables, replicated store data and extended load data for the current lane.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = rs2_reg;
    byte_sh    = mem_rdata_i >> {lane, 3'b000};
    half_sh    = mem_rdata_i >> {lane[1], 4'b0000};
    load_ext   = mem_rdata_i;
    if (size_b) begin
      be_calc    = 4'b0001 << lane;
      wdata_calc = {4{rs2_reg[7:0]}};
      load_ext   = {{24{~funct3_reg[2] & byte_sh[7]}}, byte_sh[7:0]};
    end else if (size_h) begin
      // Halfword lane is forced even; an odd address selects the enclosing half.
      be_calc    = 4'b0011 << {lane[1], 1'b0};
      wdata_calc = {2{rs2_reg[15:0]}};
      load_ext   = {{16{~funct3_reg[2] & half_sh[15]}}, half_sh[15:0]};
    end
  end

  // State and datapath registers; reset clears every visible output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      ea_reg          <= '0;
      funct3_reg      <= '0;
      we_reg          <= 1'b0;
      rs2_reg         <= '0;
      be_reg          <= '0;
      wdata_reg       <= '0;
      cnt_reg         <= '0;
      load_result_reg <= '0;
      bus_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ea_reg          <= ea_next;
      funct3_reg      <= funct3_next;
      we_reg          <= we_next;
      rs2_reg         <= rs2_next;
      be_reg          <= be_next;
      wdata_reg       <= wdata_next;
      cnt_reg         <= cnt_next;
      load_result_reg <= load_result_next;
      bus_err_reg     <= bus_err_next;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_next       = state_reg;
    ea_next          = ea_reg;
    funct3_next      = funct3_reg;
    we_next          = we_reg;
    rs2_next         = rs2_reg;
    be_next          = be_reg;
    wdata_next       = wdata_reg;
    cnt_next         = cnt_reg;
    load_result_next = load_result_reg;
    bus_err_next     = bus_err_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          bus_err_next = 1'b0;
          cnt_next     = '0;
          if (is_load_i || is_store_i) begin
            ea_next     = rs1_val_i + imm_i;
            funct3_next = funct3_i;
            we_next     = is_store_i;   // both flags set behaves as a store
            rs2_next    = rs2_val_i;
            state_next  = ADDR;
          end else begin
            state_next  = DONE;         // no-op access completes without the bus
          end
        end
      end
      ADDR: begin
        be_next    = be_calc;
        wdata_next = wdata_calc;
        cnt_next   = '0;
        if (misalign) begin
          bus_err_next = 1'b1;
          state_next   = DONE;
        end else begin
          state_next   = REQ;
        end
      end
      REQ: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (mem_ack_i) begin
          state_next = DONE;
          if (!we_reg) begin
            load_result_next = load_ext;
          end
        end else if ((BUS_TIMEOUT != 0) && (cnt_reg == BUS_TIMEOUT - 1)) begin
          bus_err_next = 1'b1;
          state_next   = DONE;
        end else if (BUS_TIMEOUT != 0) begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_req_o     = (state_reg == REQ);
  assign mem_we_o      = we_reg;
  assign mem_addr_o    = {ea_reg[31:2], 2'b00};
  assign mem_wdata_o   = wdata_reg;
  assign mem_be_o      = be_reg;
  assign busy_o        = (state_reg != IDLE);
  assign done_o        = (state_reg == DONE);
  assign load_result_o = load_result_reg;
  assign bus_err_o     = bus_err_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl (BUS_TIMEOUT = 4).
module tb_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        is_load_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_val_i;
  logic [31:0] imm_i;
  logic [31:0] rs2_val_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] load_result_o;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.BUS_TIMEOUT(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .is_load_i    (is_load_i),
    .is_store_i   (is_store_i),
    .funct3_i     (funct3_i),
    .rs1_val_i    (rs1_val_i),
    .imm_i        (imm_i),
    .rs2_val_i    (rs2_val_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .load_result_o(load_result_o),
    .bus_err_o    (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Presents a one-cycle start pulse; on return the DUT has sampled it.
  task automatic launch(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] imm,
                        input logic [31:0] rs2);
    start_i    = 1'b1;
    is_load_i  = ld;
    is_store_i = st;
    funct3_i   = f3;
    rs1_val_i  = rs1;
    imm_i      = imm;
    rs2_val_i  = rs2;
    tick();
    start_i    = 1'b0;
    is_load_i  = 1'b0;
    is_store_i = 1'b0;
  endtask

  // Drives ack with read data for one cycle; on return the DUT is in DONE.
  task automatic ack_once(input logic [31:0] rdata);
    mem_ack_i   = 1'b1;
    mem_rdata_i = rdata;
    tick();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    tick();
    tick();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b expected 0", mem_req_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done_o); end
    checks++; if (load_result_o !== 32'h0) begin errors++; $display("FAIL reset_result got %h expected 00000000", load_result_o); end
    checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", bus_err_o); end
    checks++; if (mem_be_o !== 4'h0) begin errors++; $display("FAIL reset_be got %b expected 0000", mem_be_o); end
    rst_ni = 1'b1;
    tick();
    $display("txn reset done");
  endtask

  task automatic test_lw;
    launch(1'b1, 1'b0, 3'b010, 32'h100, 32'h4, 32'h0);
    checks++; if (busy_o !== 1'b1 || mem_req_o !== 1'b0) begin errors++; $display("FAIL lw_addr_phase got busy=%b req=%b expected busy=1 req=0", busy_o, mem_req_o); end
    tick();
    checks++; if (mem_addr_o !== 32'h104) begin errors++; $display("FAIL lw_addr got %h expected 00000104", mem_addr_o); end
    checks++; if (mem_be_o !== 4'b1111) begin errors++; $display("FAIL lw_be got %b expected 1111", mem_be_o); end
    checks++; if (mem_we_o !== 1'b0) begin errors++; $display("FAIL lw_we got %b expected 0", mem_we_o); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL lw_req_wait%0d got %b expected 1", i, mem_req_o); end
      tick();
    end
    checks++; if (mem_req_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL lw_req_hold got req=%b done=%b expected req=1 done=0", mem_req_o, done_o); end
    ack_once(32'hDEADBEEF);
    checks++; if (done_o !== 1'b1 || mem_req_o !== 1'b0) begin errors++; $display("FAIL lw_done got done=%b req=%b expected done=1 req=0", done_o, mem_req_o); end
    checks++; if (load_result_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_result got %h expected deadbeef", load_result_o); end
    tick();
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL lw_pulse got done=%b busy=%b expected 0 0", done_o, busy_o); end
    $display("txn LW addr=00000104 result=%h", load_result_o);
  endtask

  task automatic test_latency;
    // Ack in the first REQ cycle: done_o three cycles after start_i.
    launch(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL lat_c1 got done=%b expected 0", done_o); end
    tick();
    ack_once(32'h01020304);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL lat_c3 got done=%b expected 1", done_o); end
    tick();
    $display("txn LW latency result=%h", load_result_o);
  endtask

  task automatic test_byte;
    launch(1'b1, 1'b0, 3'b000, 32'h100, 32'h3, 32'h0);
    tick();
    checks++; if (mem_be_o !== 4'b1000 || mem_addr_o !== 32'h100) begin errors++; $display("FAIL lb_be got be=%b addr=%h expected 1000 00000100", mem_be_o, mem_addr_o); end
    ack_once(32'h80FF0000);
    checks++; if (load_result_o !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_result got %h expected ffffff80", load_result_o); end
    tick();
    $display("txn LB result=%h", load_result_o);
    launch(1'b1, 1'b0, 3'b100, 32'h100, 32'h3, 32'h0);
    tick();
    ack_once(32'h80FF0000);
    checks++; if (load_result_o !== 32'h00000080) begin errors++; $display("FAIL lbu_result got %h expected 00000080", load_result_o); end
    tick();
    $display("txn LBU result=%h", load_result_o);
    // SB at lane 1: byte replicated, single enable.
    launch(1'b0, 1'b1, 3'b000, 32'h100, 32'h1, 32'h000000A5);
    tick();
    checks++; if (mem_be_o !== 4'b0010 || mem_wdata_o !== 32'hA5A5A5A5 || mem_we_o !== 1'b1) begin errors++; $display("FAIL sb_bus got be=%b wdata=%h we=%b expected 0010 a5a5a5a5 1", mem_be_o, mem_wdata_o, mem_we_o); end
    ack_once(32'h12345678);
    checks++; if (load_result_o !== 32'h00000080) begin errors++; $display("FAIL sb_result got %h expected 00000080", load_result_o); end
    tick();
    $display("txn SB wdata=a5a5a5a5");
  endtask

  task automatic test_store_half;
    launch(1'b0, 1'b1, 3'b001, 32'h200, 32'h2, 32'h1234ABCD);
    tick();
    checks++; if (mem_addr_o !== 32'h200) begin errors++; $display("FAIL sh_addr got %h expected 00000200", mem_addr_o); end
    checks++; if (mem_be_o !== 4'b1100) begin errors++; $display("FAIL sh_be got %b expected 1100", mem_be_o); end
    checks++; if (mem_wdata_o !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h expected abcdabcd", mem_wdata_o); end
    checks++; if (mem_we_o !== 1'b1) begin errors++; $display("FAIL sh_we got %b expected 1", mem_we_o); end
    ack_once(32'hFFFFFFFF);
    checks++; if (done_o !== 1'b1 || load_result_o !== 32'h00000080) begin errors++; $display("FAIL sh_done got done=%b result=%h expected 1 00000080", done_o, load_result_o); end
    tick();
    $display("txn SH addr=00000200 wdata=abcdabcd");
  endtask

  task automatic test_timeout;
    launch(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL to_req%0d got %b expected 1", i, mem_req_o); end
      tick();
    end
    checks++; if (mem_req_o !== 1'b0 || done_o !== 1'b1) begin errors++; $display("FAIL to_abort got req=%b done=%b expected 0 1", mem_req_o, done_o); end
    checks++; if (bus_err_o !== 1'b1) begin errors++; $display("FAIL to_err got %b expected 1", bus_err_o); end
    checks++; if (load_result_o !== 32'h00000080) begin errors++; $display("FAIL to_result got %h expected 00000080", load_result_o); end
    tick();
    checks++; if (bus_err_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL to_sticky got err=%b done=%b expected 1 0", bus_err_o, done_o); end
    $display("txn LW timeout err=%b", bus_err_o);
    // Next start clears the error; ack lands on the cycle the limit is reached.
    launch(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0);
    checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL to_clear got %b expected 0", bus_err_o); end
    tick();
    for (int i = 0; i < 3; i++) tick();
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL lim_req got %b expected 1", mem_req_o); end
    ack_once(32'h55AA55AA);
    checks++; if (bus_err_o !== 1'b0 || load_result_o !== 32'h55AA55AA) begin errors++; $display("FAIL lim_ack got err=%b result=%h expected 0 55aa55aa", bus_err_o, load_result_o); end
    tick();
    $display("txn LW ack-at-limit result=%h", load_result_o);
  endtask

  task automatic test_misalign;
`ifdef MISALIGN_TRAP_EN
    launch(1'b1, 1'b0, 3'b010, 32'h100, 32'h2, 32'h0);
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL mis_noreq got %b expected 0", mem_req_o); end
    tick();
    checks++; if (done_o !== 1'b1 || mem_req_o !== 1'b0 || bus_err_o !== 1'b1) begin errors++; $display("FAIL mis_trap got done=%b req=%b err=%b expected 1 0 1", done_o, mem_req_o, bus_err_o); end
    checks++; if (load_result_o !== 32'h55AA55AA) begin errors++; $display("FAIL mis_result got %h expected 55aa55aa", load_result_o); end
    tick();
    $display("txn LW misaligned trapped");
`else
    // LH at odd address uses the enclosing upper half.
    launch(1'b1, 1'b0, 3'b001, 32'h100, 32'h3, 32'h0);
    tick();
    checks++; if (mem_be_o !== 4'b1100 || mem_addr_o !== 32'h100) begin errors++; $display("FAIL mis_lh_be got be=%b addr=%h expected 1100 00000100", mem_be_o, mem_addr_o); end
    ack_once(32'h80010000);
    checks++; if (load_result_o !== 32'hFFFF8001 || bus_err_o !== 1'b0) begin errors++; $display("FAIL mis_lh_result got %h err=%b expected ffff8001 0", load_result_o, bus_err_o); end
    tick();
    $display("txn LH misaligned result=%h", load_result_o);
    launch(1'b1, 1'b0, 3'b010, 32'h100, 32'h2, 32'h0);
    tick();
    checks++; if (mem_be_o !== 4'b1111 || mem_addr_o !== 32'h100) begin errors++; $display("FAIL mis_lw_be got be=%b addr=%h expected 1111 00000100", mem_be_o, mem_addr_o); end
    ack_once(32'h55AA55AA);
    tick();
    $display("txn LW misaligned result=%h", load_result_o);
`endif
  endtask

  task automatic test_nop_and_busy;
    launch(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0);
    checks++; if (done_o !== 1'b1 || mem_req_o !== 1'b0) begin errors++; $display("FAIL nop_done got done=%b req=%b expected 1 0", done_o, mem_req_o); end
    tick();
    $display("txn NOP");
    // A start while busy must not disturb the running access.
    launch(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0);
    tick();
    launch(1'b0, 1'b1, 3'b000, 32'h500, 32'h1, 32'hFFFFFFFF);
    checks++; if (mem_addr_o !== 32'h400 || mem_we_o !== 1'b0 || mem_req_o !== 1'b1) begin errors++; $display("FAIL busy_ignore got addr=%h we=%b req=%b expected 00000400 0 1", mem_addr_o, mem_we_o, mem_req_o); end
    ack_once(32'h0BADF00D);
    // Back-to-back: start in the cycle after done_o is accepted.
    tick();
    launch(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h0);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b expected 1", busy_o); end
    tick();
    checks++; if (mem_addr_o !== 32'h600) begin errors++; $display("FAIL b2b_addr got %h expected 00000600", mem_addr_o); end
    ack_once(32'hCAFEF00D);
    checks++; if (load_result_o !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_result got %h expected cafef00d", load_result_o); end
    tick();
    $display("txn back-to-back result=%h", load_result_o);
  endtask

  task automatic test_reset_mid;
    launch(1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 32'h0);
    tick();
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rm_pre got req=%b expected 1", mem_req_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL rm_drop got req=%b busy=%b done=%b expected 0 0 0", mem_req_o, busy_o, done_o); end
    checks++; if (load_result_o !== 32'h0) begin errors++; $display("FAIL rm_result got %h expected 00000000", load_result_o); end
    tick();
    rst_ni = 1'b1;
    tick();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rm_nodone got %b expected 0", done_o); end
    launch(1'b1, 1'b0, 3'b001, 32'h0, 32'h0, 32'h0);
    tick();
    checks++; if (mem_be_o !== 4'b0011) begin errors++; $display("FAIL rm_lh_be got %b expected 0011", mem_be_o); end
    ack_once(32'h0000F00F);
    checks++; if (load_result_o !== 32'hFFFFF00F) begin errors++; $display("FAIL rm_lh_result got %h expected fffff00f", load_result_o); end
    tick();
    $display("txn reset-mid then LH result=%h", load_result_o);
  endtask

  initial begin
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    is_load_i   = 1'b0;
    is_store_i  = 1'b0;
    funct3_i    = 3'b000;
    rs1_val_i   = 32'h0;
    imm_i       = 32'h0;
    rs2_val_i   = 32'h0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    test_reset();
    test_lw();
    test_latency();
    test_byte();
    test_store_half();
    test_timeout();
    test_misalign();
    test_nop_and_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
